fpmul_rr_sched: RTL and testbench

- Round-robin scheduler sharing one pipelined FPmul instance among N_REQ independent requesters.
- Each requester presents operand pairs over valid/ready and receives its product over its own valid/ready response channel.
- Internal tag pipeline tracks which requester owns each in-flight product.
- Sits between requester front-ends and the FPmul datapath; FPmul is instantiated outside and wired through the mul_* ports.

---
 rtl/fpmul_rr_sched.sv | 150 +++++++++++++++
 tb/tb_fpmul_rr_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_rr_sched.sv
// fpmul_rr_sched: round-robin scheduler sharing one pipelined FPmul among N_REQ requesters.
// Define FPMUL_RR_SCHED_STATS_EN to add the stat_issued / stat_conflict counters.

module fpmul_rr_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          RST_n,
    input  logic          accept,
    input  logic          capture,
    input  logic [DW-1:0] cap_data,
    input  logic          rsp_ready,
    output logic          idle,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data
);
    typedef enum logic [1:0] {IDLE, INFLIGHT, DONE} slot_e;

    slot_e state, state_nxt;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept)    state_nxt = INFLIGHT;
            INFLIGHT: if (capture)   state_nxt = DONE;
            DONE:     if (rsp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Result register holds its value across backpressure until the next capture.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n)                              rsp_data <= '0;
        else if (capture && state == INFLIGHT)   rsp_data <= cap_data;
    end

    assign idle      = (state == IDLE);
    assign rsp_valid = (state == DONE);
endmodule

module fpmul_rr_sched #(
    parameter int N_REQ = 4,
    parameter int LAT   = 4,
    parameter int DW    = 32
) (
    input  logic                      clk,
    input  logic                      RST_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ-1:0][DW-1:0]  req_a,
    input  logic [N_REQ-1:0][DW-1:0]  req_b,
    output logic [DW-1:0]             mul_a,
    output logic [DW-1:0]             mul_b,
    input  logic [DW-1:0]             mul_z,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [N_REQ-1:0][DW-1:0]  rsp_data
`ifdef FPMUL_RR_SCHED_STATS_EN
    ,
    output logic [15:0]               stat_issued,
    output logic [15:0]               stat_conflict
`endif
);
    localparam int            IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW:0]   NR   = (IW+1)'(N_REQ);
    localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

    logic [N_REQ-1:0]         idle, elig;
    logic [IW-1:0]            ptr, gidx;
    logic [IW:0]              sum;
    logic                     gvld;
    logic [LAT:0]             vld_pipe;
    logic [LAT:0][IW-1:0]     id_pipe;

    assign elig = req_valid & idle;

    // Walk offsets from the pointer downwards so the smallest offset wins.
    always_comb begin
        gvld = 1'b0;
        gidx = '0;
        sum  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= NR) sum = sum - NR;
            if (elig[sum[IW-1:0]]) begin
                gvld = 1'b1;
                gidx = sum[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gvld && RST_n) req_ready[gidx] = 1'b1;
    end

    // Tag pipe never stalls: the multiplier behind mul_* cannot be held.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            mul_a    <= '0;
            mul_b    <= '0;
            ptr      <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LAT-1:0], gvld};
            id_pipe  <= {id_pipe[LAT-1:0], gidx};
            if (gvld) begin
                mul_a <= req_a[gidx];
                mul_b <= req_b[gidx];
                ptr   <= (gidx == LAST) ? '0 : gidx + IW'(1);
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        fpmul_rr_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .RST_n     (RST_n),
            .accept    (req_ready[i]),
            .capture   (vld_pipe[LAT] && (id_pipe[LAT] == IW'(i))),
            .cap_data  (mul_z),
            .rsp_ready (rsp_ready[i]),
            .idle      (idle[i]),
            .rsp_valid (rsp_valid[i]),
            .rsp_data  (rsp_data[i])
        );
    end

`ifdef FPMUL_RR_SCHED_STATS_EN
    logic multi;

    assign multi = |(elig & (elig - N_REQ'(1)));

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            stat_issued   <= '0;
            stat_conflict <= '0;
        end else begin
            if (gvld && stat_issued != 16'hFFFF)    stat_issued   <= stat_issued + 16'd1;
            if (multi && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fpmul_rr_sched.sv
// Bench for fpmul_rr_sched: a transaction-level model predicts grants and result delivery;
// a simple pipelined multiplier model stands in for the external FPmul.
`timescale 1ns/1ps
module tb_fpmul_rr_sched;
    localparam int N   = 4;
    localparam int LAT = 4;
    localparam int DW  = 32;

    logic                 clk = 1'b0;
    logic                 RST_n = 1'b1;
    logic [N-1:0]         req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [N-1:0][DW-1:0] req_a = '0, req_b = '0, rsp_data;
    logic [DW-1:0]        mul_a, mul_b, mul_z;
`ifdef FPMUL_RR_SCHED_STATS_EN
    logic [15:0]          stat_issued, stat_conflict;
`endif

    int n_chk = 0, n_fail = 0;

    fpmul_rr_sched #(.N_REQ(N), .LAT(LAT), .DW(DW)) dut (
        .clk(clk), .RST_n(RST_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
`ifdef FPMUL_RR_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_conflict(stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    // Normal-number single-precision multiply, truncating.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [8:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
        if (m[47]) return {s, 8'(e[7:0] + 8'd1), m[46:24]};
        return {s, e[7:0], m[45:23]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    // External multiplier: result appears LAT edges after its operands.
    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_z = mpipe[LAT-1];

    // Reference model: per-requester busy/done, countdown to delivery, rr pointer.
    logic [N-1:0] m_busy = '0, m_done = '0, exp_rdy, obs_rdy;
    logic [31:0]  m_res  [N];
    int           m_left [N];
    int           m_ptr = 0;

    function automatic logic [N-1:0] pred_grant();
        logic [N-1:0] g;
        int           i;
        g = '0;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (req_valid[i] && !m_busy[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_clear();
        m_busy = '0;
        m_done = '0;
        m_ptr  = 0;
    endtask

    task automatic tick();
        logic [N-1:0]         rr;
        logic [N-1:0][DW-1:0] a_s, b_s;
        #1;
        exp_rdy = pred_grant();
        obs_rdy = req_ready;
        rr  = rsp_ready;
        a_s = req_a;
        b_s = req_b;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (m_done[i] && rr[i]) begin
                m_done[i] = 1'b0;
                m_busy[i] = 1'b0;
            end else if (m_busy[i] && !m_done[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) m_done[i] = 1'b1;
            end
            if (exp_rdy[i]) begin
                m_busy[i] = 1'b1;
                m_left[i] = LAT + 1;
                m_res[i]  = fmul(a_s[i], b_s[i]);
                m_ptr     = (i + 1) % N;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        RST_n = 1'b1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        repeat (LAT + 3) tick();
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin req_a[i] = rnd_fp(); req_b[i] = rnd_fp(); end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_chk++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_chk++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_chk++; if (mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL reset_mul: got %h %h want 0", mul_a, mul_b); end
`ifdef FPMUL_RR_SCHED_STATS_EN
        n_chk++; if (stat_issued !== '0 || stat_conflict !== '0) begin n_fail++; $display("FAIL reset_stats: got %0d %0d want 0", stat_issued, stat_conflict); end
`endif
        req_valid = '0;
        RST_n = 1'b1;
    endtask

    task automatic test_single();
        logic [N-1:0] want;
        req_valid = 4'b0001;
        rsp_ready = '0;
        req_a[0] = 32'h40000000;
        req_b[0] = 32'h40400000;
        tick();
        n_chk++; if (obs_rdy !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b want 0001", obs_rdy); end
        n_chk++; if (mul_a !== 32'h40000000 || mul_b !== 32'h40400000) begin n_fail++; $display("FAIL single_mul_ops: got %h %h", mul_a, mul_b); end
        req_valid = '0;
        for (int c = 1; c <= LAT + 1; c++) begin
            tick();
            want = (c == LAT + 1) ? 4'b0001 : 4'b0000;
            n_chk++; if (rsp_valid !== want) begin n_fail++; $display("FAIL single_latency cyc%0d: got %b want %b", c, rsp_valid, want); end
        end
        n_chk++; if (rsp_data[0] !== 32'h40C00000) begin n_fail++; $display("FAIL single_data: got %h want 40c00000", rsp_data[0]); end
        rsp_ready = 4'b0001;
        tick();
        n_chk++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL single_handshake: got %b want 0", rsp_valid); end
    endtask

    task automatic test_all4();
        logic [31:0]  ea [N];
        logic [N-1:0] seen, oh;
        do_reset();
        req_a[0] = 32'h40000000; req_b[0] = 32'h40400000; ea[0] = 32'h40C00000;
        req_a[1] = 32'hBFC00000; req_b[1] = 32'h40800000; ea[1] = 32'hC0C00000;
        req_a[2] = 32'h3F000000; req_b[2] = 32'h3F000000; ea[2] = 32'h3E800000;
        req_a[3] = 32'h40400000; req_b[3] = 32'h40400000; ea[3] = 32'h41100000;
        rsp_ready = '1;
        req_valid = '1;
        seen = '0;
        for (int c = 0; c < N; c++) begin
            tick();
            oh = '0;
            oh[c] = 1'b1;
            n_chk++; if (obs_rdy !== oh) begin n_fail++; $display("FAIL all4_order cyc%0d: got %b want %b", c, obs_rdy, oh); end
            req_valid[c] = 1'b0;
        end
        for (int c = 0; c < LAT + 4; c++) begin
            tick();
            n_chk++; if (rsp_valid !== m_done) begin n_fail++; $display("FAIL all4_valid: got %b want %b", rsp_valid, m_done); end
            for (int i = 0; i < N; i++) if (rsp_valid[i]) begin
                seen[i] = 1'b1;
                n_chk++; if (rsp_data[i] !== ea[i]) begin n_fail++; $display("FAIL all4_data[%0d]: got %h want %h", i, rsp_data[i], ea[i]); end
            end
        end
        n_chk++; if (seen !== '1) begin n_fail++; $display("FAIL all4_seen: got %b want 1111", seen); end
`ifdef FPMUL_RR_SCHED_STATS_EN
        n_chk++; if (stat_issued !== 16'd4) begin n_fail++; $display("FAIL stat_issued: got %0d want 4", stat_issued); end
        n_chk++; if (stat_conflict !== 16'd3) begin n_fail++; $display("FAIL stat_conflict: got %0d want 3", stat_conflict); end
`endif
    endtask

    task automatic test_fair();
        int last, cnt0, cnt1;
        last = -1; cnt0 = 0; cnt1 = 0;
        rsp_ready = '1;
        req_valid = 4'b0011;
        for (int c = 0; c < 40; c++) begin
            req_a[0] = rnd_fp(); req_b[0] = rnd_fp();
            req_a[1] = rnd_fp(); req_b[1] = rnd_fp();
            tick();
            n_chk++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL fair_grant: got %b want %b", obs_rdy, exp_rdy); end
            if (obs_rdy != '0) begin
                n_chk++; if ((obs_rdy[0] && last == 0) || (obs_rdy[1] && last == 1)) begin n_fail++; $display("FAIL fair_repeat: got %b after %0d want alternation", obs_rdy, last); end
                last = obs_rdy[0] ? 0 : 1;
                if (obs_rdy[0]) cnt0++; else cnt1++;
            end
            n_chk++; if (rsp_valid !== m_done) begin n_fail++; $display("FAIL fair_valid: got %b want %b", rsp_valid, m_done); end
            for (int i = 0; i < N; i++) if (m_done[i]) begin
                n_chk++; if (rsp_data[i] !== m_res[i]) begin n_fail++; $display("FAIL fair_data[%0d]: got %h want %h", i, rsp_data[i], m_res[i]); end
            end
        end
        n_chk++; if (cnt0 < 3 || cnt1 < 3) begin n_fail++; $display("FAIL fair_count: got %0d %0d want >=3 each", cnt0, cnt1); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        bit          held_ok, g1;
        int          done_cnt [N];
        held = '0; held_ok = 1'b0; g1 = 1'b0;
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        rsp_ready = 4'b1101;
        req_valid = '1;
        for (int c = 0; c < 25; c++) begin
            for (int i = 0; i < N; i++) begin req_a[i] = rnd_fp(); req_b[i] = rnd_fp(); end
            req_a[2] = 32'h3F000000;
            req_b[2] = 32'h3F000000;
            tick();
            n_chk++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL bp_grant: got %b want %b", obs_rdy, exp_rdy); end
            if (g1) begin
                n_chk++; if (obs_rdy[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready1: got 1 want 0"); end
            end
            if (obs_rdy[1]) g1 = 1'b1;
            n_chk++; if (rsp_valid !== m_done) begin n_fail++; $display("FAIL bp_valid: got %b want %b", rsp_valid, m_done); end
            for (int i = 0; i < N; i++) if (m_done[i]) begin
                n_chk++; if (rsp_data[i] !== m_res[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, rsp_data[i], m_res[i]); end
            end
            if (rsp_valid[1]) begin
                if (held_ok) begin
                    n_chk++; if (rsp_data[1] !== held) begin n_fail++; $display("FAIL bp_stable: got %h want %h", rsp_data[1], held); end
                end else begin
                    held = rsp_data[1];
                    held_ok = 1'b1;
                end
            end
            if (rsp_valid[2]) begin
                n_chk++; if (rsp_data[2] !== 32'h3E800000) begin n_fail++; $display("FAIL bp_half: got %h want 3e800000", rsp_data[2]); end
            end
            for (int i = 0; i < N; i++) if (rsp_valid[i] && rsp_ready[i]) done_cnt[i]++;
        end
        n_chk++;
        if (!held_ok || done_cnt[0] < 2 || done_cnt[2] < 2 || done_cnt[3] < 2) begin
            n_fail++;
            $display("FAIL bp_progress: got held=%0d done %0d/%0d/%0d want held and >=2 each", held_ok, done_cnt[0], done_cnt[2], done_cnt[3]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit ok;
        rsp_ready = '1;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin req_a[i] = rnd_fp(); req_b[i] = rnd_fp(); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++; if (obs_rdy !== exp_rdy || obs_rdy == '0) begin n_fail++; $display("FAIL rmid_accept: got %b want %b", obs_rdy, exp_rdy); end
        end
        req_valid = '0;
        #2;
        RST_n = 1'b0;
        #1;
        n_chk++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || mul_a !== '0 || mul_b !== '0) begin
            n_fail++;
            $display("FAIL rmid_outputs: got rdy=%b vld=%b mul_a=%h want all zero", req_ready, rsp_valid, mul_a);
        end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        RST_n = 1'b1;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            n_chk++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL rmid_stale: got %b want 0", rsp_valid); end
        end
        req_valid = 4'b1000;
        req_a[3] = 32'h40800000;
        req_b[3] = 32'h3F000000;
        ok = 1'b0;
        for (int c = 0; c < LAT + 4 && !ok; c++) begin
            tick();
            req_valid = '0;
            if (rsp_valid[3]) begin
                ok = 1'b1;
                n_chk++; if (rsp_data[3] !== 32'h40000000) begin n_fail++; $display("FAIL rmid_fresh_data: got %h want 40000000", rsp_data[3]); end
            end
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rmid_fresh_timeout: got no rsp_valid[3] want one"); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int i = 0; i < N; i++) begin req_a[i] = rnd_fp(); req_b[i] = rnd_fp(); end
            tick();
            n_chk++; if (obs_rdy !== exp_rdy) begin n_fail++; $display("FAIL rand_grant cyc%0d: got %b want %b", c, obs_rdy, exp_rdy); end
            n_chk++; if (rsp_valid !== m_done) begin n_fail++; $display("FAIL rand_valid cyc%0d: got %b want %b", c, rsp_valid, m_done); end
            for (int i = 0; i < N; i++) if (m_done[i]) begin
                n_chk++; if (rsp_data[i] !== m_res[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, rsp_data[i], m_res[i]); end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all4();
        test_fair();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
